sync_fifo_param: RTL and testbench

//   Parametrised single-clock FIFO queue: next generation of the 16-bit/8-deep FIFO.

---
 rtl/sync_fifo_param.sv | 104 ++++++++++
 tb/tb_sync_fifo_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                     Clk_In,
  input  logic                     Reset_N_In,
  input  logic                     Flush_In,
  input  logic [DATA_WIDTH-1:0]    Data_In,
  input  logic                     Write_Enable_In,
  input  logic                     Read_Enable_In,
  input  logic                     Clear_Err_In,
  output logic [DATA_WIDTH-1:0]    Data_Out,
  output logic                     Data_Valid_Out,
  output logic                     FIFO_Empty,
  output logic                     FIFO_Full,
  output logic                     Almost_Empty,
  output logic                     Almost_Full,
  output logic [$clog2(DEPTH):0]   Fill_Count,
  output logic                     Overflow_Err,
  output logic                     Underflow_Err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [AW:0] AF_TH = PW'(ALMOST_FULL_TH);
  localparam logic [AW:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  wr_req_ok;
  logic                  rd_req_ok;

  // Status flags decode straight from the registered pointers and count.
  always_comb begin
    FIFO_Empty   = (wptr == rptr);
    FIFO_Full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    Almost_Empty = (count <= AE_TH);
    Almost_Full  = (count >= AF_TH);
    Fill_Count   = count;
    rd_ok        = Read_Enable_In & ~FIFO_Empty;
    wr_ok        = Write_Enable_In & (~FIFO_Full | rd_ok);
    wr_req_ok    = wr_ok & ~Flush_In;
    rd_req_ok    = rd_ok & ~Flush_In;
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge Clk_In) begin
    if (wr_req_ok) begin
      mem[wptr[AW-1:0]] <= Data_In;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      Data_Out       <= '0;
      Data_Valid_Out <= 1'b0;
    end else if (Flush_In) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      Data_Valid_Out <= 1'b0;
    end else begin
      Data_Valid_Out <= rd_ok;
      if (wr_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (rd_ok) begin
        Data_Out <= mem[rptr[AW-1:0]];
        rptr     <= rptr + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      Overflow_Err  <= 1'b0;
      Underflow_Err <= 1'b0;
    end else begin
      Overflow_Err  <= (~Flush_In & Write_Enable_In & ~wr_ok) | (Overflow_Err & ~Clear_Err_In);
      Underflow_Err <= (~Flush_In & Read_Enable_In & ~rd_ok) | (Underflow_Err & ~Clear_Err_In);
    end
  end

  logic unused_ok;
  assign unused_ok = rd_req_ok;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Table-driven bench for sync_fifo_param with a data scoreboard queue.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] din;
  logic        we;
  logic        re;
  logic        clr;
  logic [15:0] dout;
  logic        dv;
  logic        empty;
  logic        full;
  logic        aempty;
  logic        afull;
  logic [3:0]  cnt;
  logic        ovf;
  logic        udf;

  sync_fifo_param #(
    .DATA_WIDTH(16), .DEPTH(8), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)
  ) dut (
    .Clk_In(clk), .Reset_N_In(rst_n), .Flush_In(flush), .Data_In(din),
    .Write_Enable_In(we), .Read_Enable_In(re), .Clear_Err_In(clr),
    .Data_Out(dout), .Data_Valid_Out(dv), .FIFO_Empty(empty), .FIFO_Full(full),
    .Almost_Empty(aempty), .Almost_Full(afull), .Fill_Count(cnt),
    .Overflow_Err(ovf), .Underflow_Err(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        we;
    logic        re;
    logic        clr;
    logic [15:0] din;
    int          cnt;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] last_dout;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic vec_t mk(input logic f, input logic w, input logic r, input logic c,
                              input logic [15:0] d, input int n, input logic o, input logic u);
    vec_t v;
    v.flush = f; v.we = w; v.re = r; v.clr = c; v.din = d;
    v.cnt = n; v.ovf = o; v.udf = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int n, input logic o, input logic u,
                             input logic v, input logic [15:0] d);
    chk({tag, " count"},    32'(cnt),    32'(n));
    chk({tag, " empty"},    32'(empty),  32'(n == 0));
    chk({tag, " full"},     32'(full),   32'(n == DEPTH));
    chk({tag, " afull"},    32'(afull),  32'(n >= 6));
    chk({tag, " aempty"},   32'(aempty), 32'(n <= 2));
    chk({tag, " overflow"}, 32'(ovf),    32'(o));
    chk({tag, " underflow"},32'(udf),    32'(u));
    chk({tag, " valid"},    32'(dv),     32'(v));
    chk({tag, " data"},     32'(dout),   32'(d));
  endtask

  // Scoreboard predicts acceptance from its own occupancy, then the edge is applied.
  task automatic run_vec(input vec_t v, input string tag);
    logic r_ok;
    logic w_ok;
    logic exp_dv;
    r_ok   = v.re && (sb.size() > 0);
    w_ok   = v.we && ((sb.size() < DEPTH) || r_ok);
    exp_dv = 1'b0;
    if (v.flush) begin
      sb.delete();
    end else begin
      if (r_ok) begin
        last_dout = sb.pop_front();
        exp_dv    = 1'b1;
      end
      if (w_ok) sb.push_back(v.din);
    end
    flush = v.flush; we = v.we; re = v.re; clr = v.clr; din = v.din;
    @(posedge clk);
    #1;
    check_state(tag, v.cnt, v.ovf, v.udf, exp_dv, last_dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; din = '0;
    last_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;

    // Fill to full, then overflow.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 0, 16'(i), i, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0009, 8, 1, 0));
    // Drain in order, then underflow with data held; clear both flags.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 0, 1, 0, 16'h0, 8 - i, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0, 0, 0, 0));
    // Simultaneous read+write while full.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 0, 16'(16'h10 + i), i, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 16'hAAAA, 8, 0, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 0, 1, 0, 16'h0, 8 - i, 0, 0));
    // Simultaneous read+write while empty; set beats clear.
    vecs.push_back(mk(0, 1, 1, 0, 16'h1234, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0, 0, 0, 0));
    // Pointer wrap, then flush with a concurrent write.
    for (int i = 0; i < 20; i++) begin
      vecs.push_back(mk(0, 1, 0, 0, 16'(16'h5000 + i), 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0, 0, 0, 0));
    end
    vecs.push_back(mk(0, 0, 1, 0, 16'h0, 0, 0, 1));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 1, 0, 0, 16'(16'h6000 + i), i, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 16'h7777, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0ABC, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset between edges with three words held.
    for (int i = 1; i <= 3; i++) run_vec(mk(0, 1, 0, 0, 16'(16'h3000 + i), i, 0, 1), "pre_rst");
    we = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    last_dout = '0;
    check_state("async_rst", 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    check_state("rst_hold", 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;

    // Set both sticky flags, then clear them together.
    run_vec(mk(0, 0, 1, 0, 16'h0, 0, 0, 1), "set_udf");
    for (int i = 1; i <= 8; i++) run_vec(mk(0, 1, 0, 0, 16'(16'h9000 + i), i, 0, 1), "refill");
    run_vec(mk(0, 1, 0, 0, 16'hDEAD, 8, 1, 1), "set_ovf");
    run_vec(mk(0, 0, 0, 1, 16'h0, 8, 0, 0), "clear_err");
    for (int i = 1; i <= 8; i++) run_vec(mk(0, 0, 1, 0, 16'h0, 8 - i, 0, 0), "final_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
